// File: rtl/osc_tune_ctrl.sv
// Closed-loop ring-oscillator tuner: counts synchronized oscillator edges per
// reference window and nudges the tap chain until the count is within tolerance.
//
// state  | meaning
// IDLE   | oscillator held in reset, loop parked
// START  | oscillator released, settling at slowest tap
// MEAS   | counting oscillator edges over one window
// DECIDE | compare window count against target +/- tol
// STEP   | one-cycle ctl pulse issued, settling afterwards
// LIMIT  | required shift blocked by end-of-chain; keep measuring
module osc_tune_ctrl #(
    parameter int CW         = 16,
    parameter int WIN_CYC    = 1024,
    parameter int SETTLE_CYC = 16,
    parameter int LOCK_CNT   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [CW-1:0] target,
    input  logic [CW-1:0] tol,
    input  logic [CW-1:0] osc_cnt_g,
    input  logic [1:0]    osc_status,
    output logic          osc_resn,
    output logic [1:0]    osc_ctl,
    output logic [CW-1:0] meas,
    output logic          locked,
    output logic          at_limit,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        MEAS   = 3'd2,
        DECIDE = 3'd3,
        STEP   = 3'd4,
        LIMIT  = 3'd5
    } state_t;

    localparam int TMAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int TW   = $clog2(TMAX);
    localparam int LW   = $clog2(LOCK_CNT + 1);

    localparam logic [TW-1:0] WIN_LD   = TW'(WIN_CYC - 1);
    localparam logic [TW-1:0] SET_LD   = TW'(SETTLE_CYC - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);

    localparam logic [1:0] CTL_HOLD   = 2'b00;
    localparam logic [1:0] CTL_SLOWER = 2'b11;
    localparam logic [1:0] CTL_FASTER = 2'b10;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_s1_q, cnt_s1_d, cnt_s2_q, cnt_s2_d;
    logic [1:0]    sts_s1_q, sts_s1_d, sts_s2_q, sts_s2_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] start_q, start_d;
    logic [CW-1:0] meas_q, meas_d;
    logic [LW-1:0] lock_ctr_q, lock_ctr_d;
    logic          locked_q, locked_d;
    logic          at_limit_q, at_limit_d;
    logic          osc_resn_q, osc_resn_d;
    logic [1:0]    osc_ctl_q, osc_ctl_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] bin_now, win_cnt, cmp_val, hi_lim, lo_lim;
    logic [CW:0]   hi_sum;
    logic [LW-1:0] lock_inc;
    logic          is_hi, is_lo, blk_hi, blk_lo;

    function automatic logic [CW-1:0] gray2bin(input logic [CW-1:0] g);
        logic [CW-1:0] b;
        b[CW-1] = g[CW-1];
        for (int i = CW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // LIMIT judges its own fresh window; DECIDE judges the window just stored.
    always_comb begin
        bin_now  = gray2bin(cnt_s2_q);
        win_cnt  = bin_now - start_q;
        cmp_val  = (state_q == LIMIT) ? win_cnt : meas_q;
        hi_sum   = {1'b0, target} + {1'b0, tol};
        hi_lim   = hi_sum[CW] ? {CW{1'b1}} : hi_sum[CW-1:0];
        lo_lim   = (target > tol) ? (target - tol) : {CW{1'b0}};
        is_hi    = cmp_val > hi_lim;
        is_lo    = cmp_val < lo_lim;
        blk_hi   = is_hi && (sts_s2_q == 2'b11);
        blk_lo   = is_lo && (sts_s2_q == 2'b10);
        lock_inc = (lock_ctr_q == LOCK_MAX) ? lock_ctr_q : lock_ctr_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_s1_d   = osc_cnt_g;
        cnt_s2_d   = cnt_s1_q;
        sts_s1_d   = osc_status;
        sts_s2_d   = sts_s1_q;
        tmr_d      = tmr_q;
        start_d    = start_q;
        meas_d     = meas_q;
        lock_ctr_d = lock_ctr_q;
        locked_d   = locked_q;
        at_limit_d = at_limit_q;
        osc_resn_d = osc_resn_q;
        osc_ctl_d  = CTL_HOLD;

        case (state_q)
            IDLE: begin
                osc_resn_d = 1'b0;
                if (enable) begin
                    state_d    = START;
                    tmr_d      = SET_LD;
                    osc_resn_d = 1'b1;
                end
            end
            START, STEP: begin
                if (tmr_q == '0) begin
                    state_d = MEAS;
                    tmr_d   = WIN_LD;
                    start_d = bin_now;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            MEAS: begin
                if (tmr_q == '0) begin
                    state_d = DECIDE;
                    meas_d  = win_cnt;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            DECIDE, LIMIT: begin
                if (state_q == LIMIT && tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else begin
                    if (state_q == LIMIT) meas_d = win_cnt;
                    if (blk_hi || blk_lo) begin
                        state_d    = LIMIT;
                        at_limit_d = 1'b1;
                        lock_ctr_d = '0;
                        locked_d   = 1'b0;
                        tmr_d      = WIN_LD;
                        start_d    = bin_now;
                    end else if (is_hi || is_lo) begin
                        state_d    = STEP;
                        at_limit_d = 1'b0;
                        lock_ctr_d = '0;
                        locked_d   = 1'b0;
                        osc_ctl_d  = is_hi ? CTL_SLOWER : CTL_FASTER;
                        tmr_d      = SET_LD;
                    end else begin
                        state_d    = MEAS;
                        at_limit_d = 1'b0;
                        lock_ctr_d = lock_inc;
                        locked_d   = (lock_inc == LOCK_MAX);
                        tmr_d      = WIN_LD;
                        start_d    = bin_now;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable wins over everything except meas, which keeps its last value.
        if (!enable) begin
            state_d    = IDLE;
            osc_resn_d = 1'b0;
            osc_ctl_d  = CTL_HOLD;
            locked_d   = 1'b0;
            at_limit_d = 1'b0;
            lock_ctr_d = '0;
            meas_d     = meas_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_s1_q   <= '0;
            cnt_s2_q   <= '0;
            sts_s1_q   <= '0;
            sts_s2_q   <= '0;
            tmr_q      <= '0;
            start_q    <= '0;
            meas_q     <= '0;
            lock_ctr_q <= '0;
            locked_q   <= 1'b0;
            at_limit_q <= 1'b0;
            osc_resn_q <= 1'b0;
            osc_ctl_q  <= CTL_HOLD;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_s1_q   <= cnt_s1_d;
            cnt_s2_q   <= cnt_s2_d;
            sts_s1_q   <= sts_s1_d;
            sts_s2_q   <= sts_s2_d;
            tmr_q      <= tmr_d;
            start_q    <= start_d;
            meas_q     <= meas_d;
            lock_ctr_q <= lock_ctr_d;
            locked_q   <= locked_d;
            at_limit_q <= at_limit_d;
            osc_resn_q <= osc_resn_d;
            osc_ctl_q  <= osc_ctl_d;
            busy_q     <= busy_d;
        end
    end

    assign osc_resn = osc_resn_q;
    assign osc_ctl  = osc_ctl_q;
    assign meas     = meas_q;
    assign locked   = locked_q;
    assign at_limit = at_limit_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_osc_tune_ctrl.sv
// Bench for osc_tune_ctrl: behavioural ring-oscillator model plus a rule-level
// reference for window counts, pulse direction, pulse counts and lock timing.
module tb_osc_tune_ctrl;

    localparam int W = 64;
    localparam int S = 6;
    localparam int L = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] target;
    logic [15:0] tol;
    logic [15:0] osc_cnt_g;
    logic [1:0]  osc_status;
    logic        osc_resn;
    logic [1:0]  osc_ctl;
    logic [15:0] meas;
    logic        locked;
    logic        at_limit;
    logic        busy;

    osc_tune_ctrl #(.CW(16), .WIN_CYC(W), .SETTLE_CYC(S), .LOCK_CNT(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .target    (target),
        .tol       (tol),
        .osc_cnt_g (osc_cnt_g),
        .osc_status(osc_status),
        .osc_resn  (osc_resn),
        .osc_ctl   (osc_ctl),
        .meas      (meas),
        .locked    (locked),
        .at_limit  (at_limit),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator model: edges per window = 300 + 4*(255-tap) + drift.
    int          tap;
    int          rst_tap;
    int          drift;
    logic [15:0] base;
    logic [47:0] acc;
    logic [47:0] quo;
    logic [15:0] osc_bin;

    function automatic int rate(input int t);
        return 300 + 4 * (255 - t) + drift;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            tap <= rst_tap;
        end else if (!osc_resn) begin
            tap <= rst_tap;
        end else begin
            acc <= acc + 48'(rate(tap));
            if (osc_ctl == 2'b11 && tap < 255) tap <= tap + 1;
            else if (osc_ctl == 2'b10 && tap > 0) tap <= tap - 1;
        end
    end

    assign quo        = acc / 48'(W);
    assign osc_bin    = quo[15:0] + base;
    assign osc_cnt_g  = osc_bin ^ (osc_bin >> 1);
    assign osc_status = (tap == 255) ? 2'b11 : ((tap == 0) ? 2'b10 : 2'b00);

    int n_chk, n_pass;
    int cyc, last_pulse_cyc, nfast, nslow, meas_skip;
    logic [1:0]  prev_ctl;
    logic [15:0] prev_meas;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic int hi_b();
        int h = int'(target) + int'(tol);
        return (h > 65535) ? 65535 : h;
    endfunction

    function automatic int lo_b();
        int l = int'(target) - int'(tol);
        return (l < 0) ? 0 : l;
    endfunction

    function automatic logic [1:0] exp_dir(input int r);
        if (r > hi_b()) return 2'b11;
        if (r < lo_b()) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int steps(input int r0, input int dir);
        int k = 0;
        while (k < 300 && !((r0 + dir * 4 * k) >= lo_b() && (r0 + dir * 4 * k) <= hi_b())) k++;
        return k;
    endfunction

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return locked;
            1:       return at_limit;
            default: return osc_resn;
        endcase
    endfunction

    // One clock step with continuous pulse and window-count checks.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            if (osc_ctl != 2'b00) begin
                chk("ctl_one_cycle", 32'(prev_ctl), 32'(0));
                chk("ctl_dir", 32'(osc_ctl), 32'(exp_dir(rate(tap))));
                if (osc_ctl == 2'b11) nslow++;
                else nfast++;
                last_pulse_cyc = cyc;
            end
            if (meas != prev_meas) begin
                if (meas_skip > 0) meas_skip--;
                else chk("meas_count", 32'(meas), 32'(rate(tap)));
            end
        end
        prev_ctl  = osc_ctl;
        prev_meas = meas;
    endtask

    task automatic wait_flag(input string tag, input int sel, input logic val,
                             input int budget, output int at_cyc);
        for (int n = 0; n < budget; n++) begin
            tick();
            if (sig_of(sel) == val) break;
        end
        chk(tag, 32'(sig_of(sel)), 32'(val));
        at_cyc = cyc;
    endtask

    task automatic wait_pulse(input string tag, input int budget);
        for (int n = 0; n < budget; n++) begin
            tick();
            if (osc_ctl != 2'b00) break;
        end
        chk(tag, 32'(osc_ctl != 2'b00), 32'(1));
    endtask

    task automatic apply_reset();
        enable = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic run_lock(input int tgt, input int tl, input logic [15:0] b);
        int lc, f0, s0;
        apply_reset();
        rst_tap = 255;
        drift   = 0;
        base    = b;
        target  = 16'(tgt);
        tol     = 16'(tl);
        f0 = nfast;
        s0 = nslow;
        enable = 1'b1;
        wait_flag("lock_wait", 0, 1'b1, 30000, lc);
        chk("fast_pulses", 32'(nfast - f0), 32'(steps(300, 1)));
        chk("slow_pulses", 32'(nslow - s0), 32'(0));
        chk("lock_latency", 32'(lc - last_pulse_cyc), 32'(S + L * (W + 1)));
        chk("meas_in_tol", 32'(int'(meas) >= lo_b() && int'(meas) <= hi_b()), 32'(1));
    endtask

    initial begin
        int lc, rc, p0, s0, f0;
        n_chk = 0; n_pass = 0; cyc = 0; last_pulse_cyc = 0;
        nfast = 0; nslow = 0; meas_skip = 0;
        prev_ctl = 2'b00; prev_meas = '0;
        rst = 1'b1; enable = 1'b0; target = '0; tol = '0;
        rst_tap = 255; drift = 0; base = '0;
        tick(); tick(); tick();
        enable = 1'b1;
        tick();
        chk("rst_resn", 32'(osc_resn), 32'(0));
        chk("rst_ctl", 32'(osc_ctl), 32'(0));
        chk("rst_meas", 32'(meas), 32'(0));
        chk("rst_locked", 32'(locked), 32'(0));
        chk("rst_at_limit", 32'(at_limit), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));

        // Converge from slowest tap to 400 +/- 3.
        run_lock(400, 3, 16'h1234);

        // Drift upward while locked: loop must re-tune with slower pulses.
        drift = 20; meas_skip = 1;
        s0 = nslow; f0 = nfast;
        wait_flag("drift_unlock", 0, 1'b0, 2 * (W + 1) + 5, lc);
        wait_flag("drift_relock", 0, 1'b1, 20000, lc);
        chk("drift_slow_pulses", 32'(nslow - s0), 32'(steps(420, -1)));
        chk("drift_fast_pulses", 32'(nfast - f0), 32'(0));
        chk("drift_lock_latency", 32'(lc - last_pulse_cyc), 32'(S + L * (W + 1)));

        for (int r = 0; r < 3; r++) begin
            run_lock($urandom_range(330, 700), $urandom_range(2, 8), 16'($urandom));
        end

        // End-of-chain: fastest tap only reaches 500, target 600 is blocked.
        apply_reset();
        rst_tap = 0; drift = 500 - 1320; base = 16'($urandom);
        target = 16'd600; tol = 16'd3;
        enable = 1'b1;
        wait_flag("limit_set", 1, 1'b1, 3 * (W + 1) + 20, lc);
        p0 = nfast + nslow;
        repeat (3 * (W + 1) + S) tick();
        chk("limit_no_pulse", 32'(nfast + nslow), 32'(p0));
        chk("limit_hold", 32'(at_limit), 32'(1));
        chk("limit_busy", 32'(busy), 32'(1));
        target = 16'd450;
        s0 = nslow; f0 = nfast;
        wait_flag("limit_clear", 1, 1'b0, 2 * (W + 1) + 5, lc);
        wait_flag("limit_relock", 0, 1'b1, 20000, lc);
        chk("limit_slow_pulses", 32'(nslow - s0), 32'(steps(500, -1)));
        chk("limit_fast_pulses", 32'(nfast - f0), 32'(0));
        chk("limit_lock_latency", 32'(lc - last_pulse_cyc), 32'(S + L * (W + 1)));

        // Window straddling the wrap of the free-running counter.
        apply_reset();
        rst_tap = 250; drift = 0; base = 16'hFFE1;
        target = 16'd320; tol = 16'd3;
        enable = 1'b1;
        for (int n = 0; n < S + W + 20; n++) begin
            tick();
            if (meas != 16'h0000) break;
        end
        chk("wrap_meas", 32'(meas), 32'h0140);

        // Disable while settling after a pulse.
        apply_reset();
        rst_tap = 255; drift = 0; base = 16'($urandom);
        target = 16'd400; tol = 16'd3;
        enable = 1'b1;
        wait_pulse("step_pulse", 3 * (W + S));
        tick(); tick();
        chk("step_busy", 32'(busy), 32'(1));
        enable = 1'b0;
        tick();
        chk("dis_ctl", 32'(osc_ctl), 32'(0));
        chk("dis_resn", 32'(osc_resn), 32'(0));
        chk("dis_busy", 32'(busy), 32'(0));
        chk("dis_meas_hold", 32'(meas), 32'(300));

        // Asynchronous reset in the middle of a faster pulse.
        enable = 1'b1;
        wait_pulse("fast_pulse", 3 * (W + S));
        chk("fast_pulse_dir", 32'(osc_ctl), 32'(2'b10));
        #1 rst = 1'b1;
        #1;
        chk("arst_ctl", 32'(osc_ctl), 32'(0));
        chk("arst_resn", 32'(osc_resn), 32'(0));
        chk("arst_meas", 32'(meas), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_locked", 32'(locked), 32'(0));

        // Tolerance so wide that target+tol saturates: every window is in-tol.
        apply_reset();
        rst_tap = $urandom_range(1, 254); drift = 0; base = 16'($urandom);
        target = 16'd5; tol = 16'hFFFF;
        p0 = nfast + nslow;
        enable = 1'b1;
        wait_flag("wide_start", 2, 1'b1, 5, rc);
        wait_flag("wide_lock", 0, 1'b1, (L + 1) * (W + 1) + S + 5, lc);
        chk("wide_lock_latency", 32'(lc - rc), 32'(S + L * (W + 1)));
        chk("wide_no_pulse", 32'(nfast + nslow), 32'(p0));
        chk("wide_at_limit", 32'(at_limit), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
